enemy_move_ctrl: RTL and testbench

Per-enemy motion and life-cycle controller in the VGA game pipeline. Once per video frame it advances the enemy's fixed-point position, bounces it off the playfield limits and processes hits reported by the collision detector. It drives the top-left coordinates consumed by the enemy bitmap and heads-up bracket drawers. Visibility/activity flags gate drawing and collision downstream.

---
 rtl/enemy_pkg.sv | 20 ++
 rtl/enemy_bounce_axis.sv | 55 +++++
 rtl/enemy_move_ctrl.sv | 172 +++++++++++++++++
 tb/tb_enemy_move_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared constants and state encoding for the enemy motion/life-cycle controller.
package enemy_pkg;

    // Enemy life-cycle states
    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HIT   = 2'd1,
        DEAD  = 2'd2
    } enemy_state_e;

    // Positions and speeds are fixed point with 6 fractional bits
    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FIXED_POINT_SHIFT      = 6;

    // Playfield geometry
    localparam int SCREEN_WIDTH     = 640;
    localparam int SCREEN_HEIGHT    = 480;
    localparam int BRACKET_OFFSET_X = 5;

endpackage

// File: rtl/enemy_bounce_axis.sv
// One motion axis: fixed-point position/velocity pair that steps once per
// enabled frame and reflects off the [MIN_PIX, MAX_PIX] limits.
module enemy_bounce_axis
    import enemy_pkg::*;
#(
    parameter int MIN_PIX    = 0,
    parameter int MAX_PIX    = 100,
    parameter int INIT_PIX   = 0,
    parameter int INIT_SPEED = 0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        step_en,
    input  logic        load_init,
    output logic [10:0] pix
);

    localparam int MIN_FP  = MIN_PIX * FIXED_POINT_MULTIPLIER;
    localparam int MAX_FP  = MAX_PIX * FIXED_POINT_MULTIPLIER;
    localparam int INIT_FP = INIT_PIX * FIXED_POINT_MULTIPLIER;

    logic signed [31:0] pos_reg;
    logic signed [31:0] speed_reg;
    logic signed [31:0] pos_sum;

    // Candidate position for this frame before limit checks
    always_comb begin
        pos_sum = pos_reg + speed_reg;
    end

    // Step, bounce (clamp to limit and reverse) or reload the spawn values
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pos_reg   <= INIT_FP;
            speed_reg <= INIT_SPEED;
        end else if (load_init) begin
            pos_reg   <= INIT_FP;
            speed_reg <= INIT_SPEED;
        end else if (step_en) begin
            if (pos_sum < MIN_FP) begin
                pos_reg   <= MIN_FP;
                speed_reg <= -speed_reg;
            end else if (pos_sum > MAX_FP) begin
                pos_reg   <= MAX_FP;
                speed_reg <= -speed_reg;
            end else begin
                pos_reg <= pos_sum;
            end
        end
    end

    // Integer pixel = position >>> 6, keeping the low 11 bits
    assign pix = pos_reg[FIXED_POINT_SHIFT +: 11];

endmodule

// File: rtl/enemy_move_ctrl.sv
// Per-enemy motion and life-cycle controller. Once per frame: moves and
// bounces the enemy while ALIVE, consumes hits, flashes while HIT and hides
// for a respawn period while DEAD.
// Optional feature macro ENEMY_VERTICAL_MOVE_EN: when defined the Y axis
// moves and bounces; otherwise topLeftY is held at INITIAL_Y.
module enemy_move_ctrl
    import enemy_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 64,
    parameter int INITIAL_Y_SPEED = 32,
    parameter int OBJECT_WIDTH_X  = 20,
    parameter int OBJECT_HEIGHT_Y = 20,
    parameter int HEADS_UP_HEIGHT = 80,
    parameter int HIT_POINTS      = 3,
    parameter int FLASH_FRAMES    = 16,
    parameter int RESPAWN_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        enemyVisible,
    output logic        enemyActive,
    output logic [2:0]  hitsLeft
);

    localparam logic [1:0] ST_ALIVE = ALIVE;
    localparam logic [1:0] ST_HIT   = HIT;
    localparam logic [1:0] ST_DEAD  = DEAD;

    localparam int X_MIN_PIX = BRACKET_OFFSET_X;
    localparam int X_MAX_PIX = SCREEN_WIDTH - OBJECT_WIDTH_X - BRACKET_OFFSET_X;
    localparam int Y_MIN_PIX = HEADS_UP_HEIGHT;
    localparam int Y_MAX_PIX = SCREEN_HEIGHT - OBJECT_HEIGHT_Y;

    logic [1:0] state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [2:0] hits_reg, hits_next;
    logic       pending_reg, pending_next;
    logic       visible_reg, visible_next;
    logic       active_reg, active_next;
    logic       hit_now;
    logic       step_en;
    logic       load_init;

    // Frame-boundary state machine; nothing changes between startOfFrame pulses
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hits_next  = hits_reg;
        step_en    = 1'b0;
        load_init  = 1'b0;
        // A collision on the startOfFrame cycle belongs to the frame being closed
        hit_now    = pending_reg | collision;
        if (startOfFrame) begin
            case (state_reg)
                ST_ALIVE: begin
                    if (hit_now) begin
                        hits_next = hits_reg - 3'd1;
                        if (hits_reg == 3'd1) begin
                            state_next = ST_DEAD;
                            cnt_next   = 8'(RESPAWN_FRAMES);
                        end else begin
                            state_next = ST_HIT;
                            cnt_next   = 8'(FLASH_FRAMES);
                        end
                    end else begin
                        step_en = 1'b1;
                    end
                end
                ST_HIT: begin
                    cnt_next = cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) begin
                        state_next = ST_ALIVE;
                    end
                end
                ST_DEAD: begin
                    cnt_next = cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) begin
                        state_next = ST_ALIVE;
                        load_init  = 1'b1;
                        hits_next  = 3'(HIT_POINTS);
                    end
                end
                default: begin
                    state_next = ST_ALIVE;
                end
            endcase
        end
    end

    // Hit latch: remembers any collision seen while ALIVE until the next frame boundary
    always_comb begin
        pending_next = pending_reg;
        if (startOfFrame || (state_reg != ST_ALIVE)) begin
            pending_next = 1'b0;
        end else if (collision) begin
            pending_next = 1'b1;
        end
    end

    // Flags decoded from the next state so they are registered alongside it
    always_comb begin
        active_next = (state_next == ST_ALIVE);
        case (state_next)
            ST_ALIVE: visible_next = 1'b1;
            ST_HIT:   visible_next = cnt_next[2];
            default:  visible_next = 1'b0;
        endcase
    end

    // Life-cycle registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg   <= ST_ALIVE;
            cnt_reg     <= '0;
            hits_reg    <= 3'(HIT_POINTS);
            pending_reg <= 1'b0;
            visible_reg <= 1'b1;
            active_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hits_reg    <= hits_next;
            pending_reg <= pending_next;
            visible_reg <= visible_next;
            active_reg  <= active_next;
        end
    end

    enemy_bounce_axis #(
        .MIN_PIX    (X_MIN_PIX),
        .MAX_PIX    (X_MAX_PIX),
        .INIT_PIX   (INITIAL_X),
        .INIT_SPEED (INITIAL_X_SPEED)
    ) u_axis_x (
        .clk       (clk),
        .resetN    (resetN),
        .step_en   (step_en),
        .load_init (load_init),
        .pix       (topLeftX)
    );

`ifdef ENEMY_VERTICAL_MOVE_EN
    enemy_bounce_axis #(
        .MIN_PIX    (Y_MIN_PIX),
        .MAX_PIX    (Y_MAX_PIX),
        .INIT_PIX   (INITIAL_Y),
        .INIT_SPEED (INITIAL_Y_SPEED)
    ) u_axis_y (
        .clk       (clk),
        .resetN    (resetN),
        .step_en   (step_en),
        .load_init (load_init),
        .pix       (topLeftY)
    );
`else
    // Without vertical motion the Y speed and limits have no effect; they are
    // folded to zero so the constant spawn row is the only thing that remains.
    localparam int Y_DISCARDED = (INITIAL_Y_SPEED + Y_MIN_PIX + Y_MAX_PIX) * 0;
    assign topLeftY = 11'(INITIAL_Y + Y_DISCARDED);
`endif

    assign hitsLeft     = hits_reg;
    assign enemyVisible = visible_reg;
    assign enemyActive  = active_reg;

endmodule

// File: tb/tb_enemy_move_ctrl.sv
// Self-checking bench for enemy_move_ctrl: reset checks, a table of frame
// vectors with hand-derived expectations, hand sequences for bounce and
// mid-HIT reset, then random frames against a behavioural model.
module tb_enemy_move_ctrl;

`ifdef ENEMY_VERTICAL_MOVE_EN
    localparam int Y_MOV = 1;
`else
    localparam int Y_MOV = 0;
`endif

    localparam int MA = 0;
    localparam int MH = 1;
    localparam int MD = 2;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        collision;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        enemyVisible;
    logic        enemyActive;
    logic [2:0]  hitsLeft;

    int n_cmp;
    int n_bad;

    enemy_move_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .collision    (collision),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .enemyVisible (enemyVisible),
        .enemyActive  (enemyActive),
        .hitsLeft     (hitsLeft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_pos [2];
    int m_vel [2];
    int m_lo  [2];
    int m_hi  [2];
    int m_mode;
    int m_cnt;
    int m_hits;
    bit m_pend;

    function automatic void model_spawn();
        m_pos[0] = 280 * 64;
        m_vel[0] = 64;
        m_pos[1] = 185 * 64;
        m_vel[1] = 32;
        m_hits   = 3;
        m_mode   = MA;
    endfunction

    function automatic void model_reset();
        model_spawn();
        m_cnt  = 0;
        m_pend = 1'b0;
    endfunction

    function automatic void model_axis(int a);
        int nx;
        nx = m_pos[a] + m_vel[a];
        if (nx < m_lo[a] * 64) begin
            m_pos[a] = m_lo[a] * 64;
            m_vel[a] = -m_vel[a];
        end else if (nx > m_hi[a] * 64) begin
            m_pos[a] = m_hi[a] * 64;
            m_vel[a] = -m_vel[a];
        end else begin
            m_pos[a] = nx;
        end
    endfunction

    function automatic void model_step(bit sof, bit col);
        if (sof) begin
            if (m_mode == MA) begin
                if (m_pend || col) begin
                    m_hits = m_hits - 1;
                    if (m_hits == 0) begin
                        m_mode = MD;
                        m_cnt  = 60;
                    end else begin
                        m_mode = MH;
                        m_cnt  = 16;
                    end
                end else begin
                    model_axis(0);
                    if (Y_MOV == 1) model_axis(1);
                end
            end else if (m_mode == MH) begin
                if (m_cnt == 1) m_mode = MA;
                m_cnt = m_cnt - 1;
            end else begin
                if (m_cnt == 1) model_spawn();
                m_cnt = m_cnt - 1;
            end
            m_pend = 1'b0;
        end else if (m_mode != MA) begin
            m_pend = 1'b0;
        end else if (col) begin
            m_pend = 1'b1;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int ey, input int eh,
                           input int ev, input int ea);
        chk({tag, ".x"},       int'(topLeftX), ex);
        chk({tag, ".y"},       int'(topLeftY), ey);
        chk({tag, ".hits"},    int'(hitsLeft), eh);
        chk({tag, ".visible"}, int'(enemyVisible), ev);
        chk({tag, ".active"},  int'(enemyActive), ea);
    endtask

    task automatic chk_model(input string tag);
        int ev;
        if (m_mode == MA)      ev = 1;
        else if (m_mode == MH) ev = (m_cnt >> 2) & 1;
        else                   ev = 0;
        chk_all(tag, (m_pos[0] >>> 6) & 'h7FF, (m_pos[1] >>> 6) & 'h7FF, m_hits,
                ev, (m_mode == MA) ? 1 : 0);
    endtask

    // One clock cycle: inputs applied at the negedge, outputs sampled at the next negedge
    task automatic cycle(input bit sof, input bit col);
        startOfFrame = sof;
        collision    = col;
        @(posedge clk);
        model_step(sof, col);
        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
    endtask

    task automatic run_frame(input int len, input bit col_sof, input bit col_mid);
        cycle(1'b1, col_sof);
        for (int i = 1; i < len; i++) begin
            cycle(1'b0, col_mid && (i == 2));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1 chk_all(tag, 280, 185, 3, 1, 1);
        model_reset();
        $display("reset %s: x=%0d y=%0d hits=%0d vis=%0d act=%0d", tag,
                 topLeftX, topLeftY, hitsLeft, enemyVisible, enemyActive);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int reps;
        bit col_sof;
        bit col_mid;
        int ex;
        int ey;
        int eh;
        bit ev;
        bit ea;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(int reps, bit cs, bit cm, int ex, int ey, int eh, bit ev, bit ea);
        vec_t v;
        v.reps = reps; v.col_sof = cs; v.col_mid = cm;
        v.ex = ex; v.ey = ey; v.eh = eh; v.ev = ev; v.ea = ea;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        resetN = 1'b1;
        startOfFrame = 1'b0;
        collision = 1'b0;
        m_lo[0] = 5;  m_hi[0] = 615;
        m_lo[1] = 80; m_hi[1] = 460;
        model_reset();

        // Expected values after each row, frames of 4 cycles, mid collision on cycle 2
        vecs[0]  = mk(10, 1'b0, 1'b0, 290, 185 + 5 * Y_MOV, 3, 1'b1, 1'b1);
        vecs[1]  = mk(1,  1'b0, 1'b1, 291, 185 + 5 * Y_MOV, 3, 1'b1, 1'b1);
        vecs[2]  = mk(1,  1'b0, 1'b0, 291, 185 + 5 * Y_MOV, 2, 1'b0, 1'b0);
        vecs[3]  = mk(1,  1'b0, 1'b0, 291, 185 + 5 * Y_MOV, 2, 1'b1, 1'b0);
        vecs[4]  = mk(3,  1'b0, 1'b0, 291, 185 + 5 * Y_MOV, 2, 1'b1, 1'b0);
        vecs[5]  = mk(1,  1'b0, 1'b0, 291, 185 + 5 * Y_MOV, 2, 1'b0, 1'b0);
        vecs[6]  = mk(10, 1'b0, 1'b0, 291, 185 + 5 * Y_MOV, 2, 1'b0, 1'b0);
        vecs[7]  = mk(1,  1'b0, 1'b0, 291, 185 + 5 * Y_MOV, 2, 1'b1, 1'b1);
        vecs[8]  = mk(1,  1'b0, 1'b0, 292, 185 + 6 * Y_MOV, 2, 1'b1, 1'b1);
        vecs[9]  = mk(1,  1'b1, 1'b0, 292, 185 + 6 * Y_MOV, 1, 1'b0, 1'b0);
        vecs[10] = mk(16, 1'b1, 1'b1, 292, 185 + 6 * Y_MOV, 1, 1'b1, 1'b1);
        vecs[11] = mk(1,  1'b0, 1'b0, 292, 185 + 6 * Y_MOV, 0, 1'b0, 1'b0);
        vecs[12] = mk(59, 1'b1, 1'b1, 292, 185 + 6 * Y_MOV, 0, 1'b0, 1'b0);
        vecs[13] = mk(1,  1'b0, 1'b0, 280, 185,             3, 1'b1, 1'b1);
        vecs[14] = mk(1,  1'b0, 1'b0, 281, 185,             3, 1'b1, 1'b1);

        do_reset("initial");

        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < vecs[r].reps; k++) begin
                run_frame(4, vecs[r].col_sof, vecs[r].col_mid);
            end
            chk_all($sformatf("vec%0d", r), vecs[r].ex, vecs[r].ey, vecs[r].eh,
                    int'(vecs[r].ev), int'(vecs[r].ea));
            $display("vec %0d: reps=%0d x=%0d y=%0d hits=%0d vis=%0d act=%0d", r, vecs[r].reps,
                     topLeftX, topLeftY, hitsLeft, enemyVisible, enemyActive);
        end

        // Hit on the startOfFrame cycle, then asynchronous reset in the middle of HIT
        run_frame(4, 1'b1, 1'b0);
        chk("sof_hit.hits", int'(hitsLeft), 2);
        chk("sof_hit.active", int'(enemyActive), 0);
        $display("sof hit: hits=%0d act=%0d", hitsLeft, enemyActive);
        do_reset("mid_hit");

        // Right-hand bounce: exact landing on 615 is not a bounce, the next step is
        for (int n = 1; n <= 338; n++) begin
            run_frame(2, 1'b0, 1'b0);
            if (n >= 335) begin
                int ex;
                if (n <= 336) ex = 615;
                else          ex = 615 - (n - 336);
                chk($sformatf("bounce%0d.x", n), int'(topLeftX), ex);
                chk($sformatf("bounce%0d.y", n), int'(topLeftY), 185 + Y_MOV * (n / 2));
                $display("bounce frame %0d: x=%0d y=%0d", n, topLeftX, topLeftY);
            end
        end

        // Random frames against the model, including back-to-back startOfFrame
        do_reset("random");
        for (int f = 0; f < 500; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                bit col;
                col = ($urandom_range(0, 29) == 0);
                cycle(c == 0, col);
                chk_model($sformatf("rand%0d.%0d", f, c));
            end
            $display("rand frame %0d: len=%0d x=%0d y=%0d hits=%0d vis=%0d act=%0d", f, len,
                     topLeftX, topLeftY, hitsLeft, enemyVisible, enemyActive);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
